// File: rtl/ncl_word_capture_if.sv
// Bus bundle for ncl_word_capture: dual-rail word and completeness ack from the NCL side,
// valid/ready word delivery and sticky error flags on the clocked side.
interface ncl_word_capture_if #(
  parameter int WIDTH = 32
);
  logic [2*WIDTH-1:0] sumin;
  logic               sumcomp;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic               illegal_err;
  logic               seq_err;

  modport slave (
    input  sumin, out_ready,
    output sumcomp, out_data, out_valid, illegal_err, seq_err
  );

  modport master (
    output sumin, out_ready,
    input  sumcomp, out_data, out_valid, illegal_err, seq_err
  );
endinterface

// File: rtl/ncl_word_capture.sv
// Clocked capture of a dual-rail NCL word with completeness ack and one-entry valid/ready buffer.
// Optional sequence check (last+1) enabled by defining NCL_CAPTURE_SEQ_CHECK_EN.

// Per-bit synchroniser plus previous-sample compare register for one dual-rail pair.
module ncl_wc_lane #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       init,
  input  logic [1:0] rails_i,
  output logic       data_o,
  output logic       null_o,
  output logic       ill_o,
  output logic       stable_o,
  output logic       bit_o
);
  logic [SYNC_STAGES-1:0][1:0] sync_q;
  logic [1:0]                  p_q;
  logic [1:0]                  s;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (init) begin
      sync_q <= '0;
      p_q    <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rails_i};
      p_q    <= s;
    end
  end

  assign data_o   = s[1] ^ s[0];
  assign null_o   = ~|s;
  assign ill_o    = &s;
  assign stable_o = (s == p_q);
  assign bit_o    = s[1];
endmodule

module ncl_word_capture #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2   // must be >= 2
) (
  input  logic                 clk,
  input  logic                 init,
  ncl_word_capture_if.slave    bus
);
  typedef enum logic {WAIT_DATA, WAIT_NULL} state_e;

  logic [WIDTH-1:0] lane_data, lane_null, lane_ill, lane_stable, lane_bit;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    ncl_wc_lane #(.SYNC_STAGES(SYNC_STAGES)) u_lane (
      .clk      (clk),
      .init     (init),
      .rails_i  (bus.sumin[2*i +: 2]),
      .data_o   (lane_data[i]),
      .null_o   (lane_null[i]),
      .ill_o    (lane_ill[i]),
      .stable_o (lane_stable[i]),
      .bit_o    (lane_bit[i])
    );
  end

  logic data_cmp, null_cmp;
  assign data_cmp = (&lane_data) & (&lane_stable);
  assign null_cmp = (&lane_null) & (&lane_stable);

  state_e           state_q, state_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             ill_q, ill_d;
  logic             cap, accept;

  assign accept = valid_q & bus.out_ready;

  always_comb begin
    state_d = state_q;
    cap     = 1'b0;
    case (state_q)
      WAIT_DATA: if (data_cmp && !valid_q) begin
        cap     = 1'b1;
        state_d = WAIT_NULL;
      end
      // Ack may only return to DATA once the buffered word is gone
      WAIT_NULL: if (null_cmp && (!valid_q || bus.out_ready)) state_d = WAIT_DATA;
      default:   state_d = WAIT_DATA;
    endcase
    valid_d = cap ? 1'b1 : (accept ? 1'b0 : valid_q);
    data_d  = cap ? lane_bit : data_q;
    ill_d   = ill_q | (|lane_ill);
  end

  always_ff @(posedge clk) begin
    if (init) begin
      state_q <= WAIT_DATA;
      valid_q <= 1'b0;
      data_q  <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      ill_q   <= ill_d;
    end
  end

  assign bus.sumcomp     = (state_q == WAIT_NULL);
  assign bus.out_valid   = valid_q;
  assign bus.out_data    = data_q;
  assign bus.illegal_err = ill_q;

`ifdef NCL_CAPTURE_SEQ_CHECK_EN
  logic [WIDTH-1:0] last_q, last_d, exp_w;
  logic             seen_q, seen_d, seq_q, seq_d;

  assign exp_w = last_q + WIDTH'(1);

  always_comb begin
    last_d = last_q;
    seen_d = seen_q;
    seq_d  = seq_q;
    if (cap) begin
      last_d = lane_bit;
      seen_d = 1'b1;
      // First word after init only seeds the register
      if (seen_q && (lane_bit != exp_w)) seq_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (init) begin
      last_q <= '0;
      seen_q <= 1'b0;
      seq_q  <= 1'b0;
    end else begin
      last_q <= last_d;
      seen_q <= seen_d;
      seq_q  <= seq_d;
    end
  end

  assign bus.seq_err = seq_q;
`else
  assign bus.seq_err = 1'b0;
`endif
endmodule
